fft_in_stream: RTL and testbench

Input-side streaming responder for the FFT processor core's input port. Accepts signed integer samples from an ADC-style valid/ready source and buffers them in a show-ahead FIFO. Pops one sample per processor input request. Raises a one-cycle interrupt each time a complete FFT frame of 2^FFTSIZ samples has been accepted. Sits between the sample source and the processor wrapper's `io_in`/`req_in`/`itr` pins.

---
 rtl/fft_in_stream.sv | 77 +++++++
 tb/tb_fft_in_stream.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fft_in_stream.sv
// Input-side sample FIFO for the FFT core: valid/ready write port, show-ahead read on req_in,
// one-cycle frame interrupt every 2^FFTSIZ accepted samples, sticky overflow/underflow flags.
module fft_in_stream #(
  parameter int NBITS  = 23,
  parameter int FFTSIZ = 3,
  parameter int DLOG   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [NBITS-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic signed [NBITS-1:0] io_in,
  input  logic                    req_in,
  output logic                    itr,
  output logic [DLOG:0]           level,
  output logic                    ovf,
  output logic                    unf,
  input  logic                    clr
);

  localparam int            DEPTH   = 2 ** DLOG;
  localparam logic [DLOG:0] LVL_FULL = {1'b1, {DLOG{1'b0}}};
  localparam logic [DLOG:0] LVL_ONE  = {{DLOG{1'b0}}, 1'b1};

  logic signed [NBITS-1:0] mem [DEPTH];
  logic [DLOG-1:0]   wptr;
  logic [DLOG-1:0]   rptr;
  logic [FFTSIZ-1:0] fcnt;
  logic              empty;
  logic              wr;
  logic              rd;

  assign empty   = (level == '0);
  assign s_ready = (level != LVL_FULL);
  assign wr      = s_valid & s_ready;
  assign rd      = req_in & ~empty;

  // Asynchronous read so the head is valid in the same cycle req_in samples it.
  assign io_in = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      fcnt  <= '0;
      itr   <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + DLOG'(1);
      if (rd) rptr <= rptr + DLOG'(1);

      case ({wr, rd})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      if (wr) fcnt <= fcnt + FFTSIZ'(1);
      itr <= wr && (fcnt == '1);

      // A set event in the same cycle as clr takes priority.
      if (s_valid && !s_ready) ovf <= 1'b1;
      else if (clr)            ovf <= 1'b0;

      if (req_in && empty) unf <= 1'b1;
      else if (clr)        unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_in_stream.sv
// Directed bench for fft_in_stream: single write, frame interrupts, full/overflow,
// underflow, sustained traffic with pointer wrap, and reset mid-frame.
module tb_fft_in_stream;

  localparam int NBITS  = 23;
  localparam int FFTSIZ = 3;
  localparam int DLOG   = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [NBITS-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [NBITS-1:0] io_in;
  logic                    req_in;
  logic                    itr;
  logic [DLOG:0]           level;
  logic                    ovf;
  logic                    unf;
  logic                    clr;

  int n_checks = 0;
  int n_errors = 0;
  int itr_cnt  = 0;
  int itr_dbl  = 0;
  logic itr_q  = 1'b0;

  fft_in_stream #(.NBITS(NBITS), .FFTSIZ(FFTSIZ), .DLOG(DLOG)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .io_in(io_in), .req_in(req_in), .itr(itr), .level(level), .ovf(ovf),
    .unf(unf), .clr(clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (itr) itr_cnt++;
    if (itr && itr_q) itr_dbl++;
    itr_q = itr;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs; returns #1 after the edge so outputs can be checked.
  task automatic step(input bit v, input int d, input bit rq, input bit c);
    int dv;
    dv      = d;
    s_valid = v;
    s_data  = dv[NBITS-1:0];
    req_in  = rq;
    clr     = c;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    req_in  = 1'b0;
    clr     = 1'b0;
  endtask

  // Assert reset mid-cycle, verify outputs drop immediately, then release.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_level"},   int'(level),   0);
    check({tag, "_s_ready"}, int'(s_ready), 1);
    check({tag, "_io_in"},   int'(io_in),   0);
    check({tag, "_itr"},     int'(itr),     0);
    check({tag, "_ovf"},     int'(ovf),     0);
    check({tag, "_unf"},     int'(unf),     0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; req_in = 1'b0; clr = 1'b0;
    #1;
    check("rst_level",   int'(level),   0);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_io_in",   int'(io_in),   0);
    check("rst_itr",     int'(itr),     0);
    check("rst_ovf",     int'(ovf),     0);
    check("rst_unf",     int'(unf),     0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write then pop
    step(1, 100, 0, 0);
    check("w1_io_in", int'(io_in), 100);
    check("w1_level", int'(level), 1);
    check("w1_itr",   int'(itr),   0);
    step(0, 0, 1, 0);
    check("p1_level", int'(level), 0);
    check("p1_io_in", int'(io_in), 0);

    // Two frames of negative samples fill the FIFO
    do_reset("rst2");
    itr_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1, -i, 0, 0);
      check($sformatf("frame_itr_%0d", i), int'(itr), (i % 8 == 0) ? 1 : 0);
    end
    step(0, 0, 0, 0);
    check("frame_itr_after", int'(itr), 0);
    check("frame_itr_cnt",   itr_cnt,   2);
    check("full_level",   int'(level),   16);
    check("full_s_ready", int'(s_ready), 0);

    step(1, 999, 0, 0);
    check("ovf_set",   int'(ovf),   1);
    check("ovf_level", int'(level), 16);
    check("ovf_head",  int'(io_in), -1);
    step(1, 998, 0, 1);
    check("ovf_set_wins", int'(ovf), 1);
    step(0, 0, 0, 1);
    check("ovf_clr", int'(ovf), 0);

    for (int i = 1; i <= 16; i++) begin
      check($sformatf("drain_%0d", i), int'(io_in), -i);
      step(0, 0, 1, 0);
      if (i == 1) check("full_pop_s_ready", int'(s_ready), 1);
    end
    check("drain_level", int'(level), 0);
    check("drain_ovf",   int'(ovf),   0);
    check("drain_unf",   int'(unf),   0);

    // Underflow, then write-while-empty with a concurrent request
    step(0, 0, 1, 0);
    check("unf_set",   int'(unf),   1);
    check("unf_level", int'(level), 0);
    step(1, 5, 1, 0);
    check("unf_hold",  int'(unf),   1);
    check("unf_wlvl",  int'(level), 1);
    check("unf_io_in", int'(io_in), 5);
    step(0, 0, 0, 1);
    check("unf_clr", int'(unf), 0);
    step(0, 0, 1, 0);
    check("unf_pop_level", int'(level), 0);
    check("unf_pop_unf",   int'(unf),   0);

    // Sustained one-in/one-out for 40 samples
    do_reset("rst3");
    itr_cnt = 0;
    step(1, 1000, 0, 0);
    for (int k = 1; k < 40; k++) begin
      check($sformatf("stream_data_%0d", k), int'(io_in), 1000 + k - 1);
      step(1, 1000 + k, 1, 0);
      check($sformatf("stream_level_%0d", k), int'(level), 1);
    end
    check("stream_last", int'(io_in), 1039);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("stream_end_level", int'(level), 0);
    check("stream_itr_cnt",   itr_cnt,     5);

    // Reset in the middle of a frame discards it
    for (int i = 0; i < 5; i++) step(1, 201 + i, 0, 0);
    check("mid_level", int'(level), 5);
    do_reset("rst4");
    itr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 301 + i, 0, 0);
      check($sformatf("post_itr_%0d", i + 1), int'(itr), (i == 7) ? 1 : 0);
    end
    step(0, 0, 0, 0);
    check("post_itr_cnt", itr_cnt,      1);
    check("post_head",    int'(io_in),  301);
    check("post_level",   int'(level),  8);

    check("itr_never_double", itr_dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
